formula_1_isqrt_sequencer: RTL



---
 rtl/formula_1_isqrt_sequencer_pkg.sv | 20 ++
 rtl/formula_1_isqrt_sequencer_if.sv | 14 +
 rtl/formula_1_isqrt_sequencer_isqrt.sv | 57 +++++
 rtl/formula_1_isqrt_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/formula_1_isqrt_sequencer_pkg.sv
// Shared types and constants for the time-multiplexed isqrt formula sequencer.
package formula_1_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S_A  = 2'd1,
    S_B  = 2'd2,
    S_C  = 2'd3
  } seq_state_e;

  // Return-side phase: which operand's root the next y_vld carries.
  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  localparam int ROOT_W = 16;
  localparam int ACC_W  = 18;
  localparam int DATA_W = 32;

endpackage

// File: rtl/formula_1_isqrt_sequencer_if.sv
// Argument/result handshake bundle between a requester and the sequencer.
interface formula_1_isqrt_sequencer_if;
  logic        arg_vld;
  logic        arg_rdy;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        res_vld;
  logic [31:0] res;
  logic        busy;

  modport master (output arg_vld, a, b, c, input arg_rdy, res_vld, res, busy);
  modport slave  (input arg_vld, a, b, c, output arg_rdy, res_vld, res, busy);
endinterface

// File: rtl/formula_1_isqrt_sequencer_isqrt.sv
// Fully pipelined 32-bit integer square root: one root bit per stage, 16 cycles x_vld to y_vld.
module formula_1_isqrt_sequencer_isqrt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_vld_i,
  input  logic [31:0] x_i,
  output logic        y_vld_o,
  output logic [15:0] y_o
);

  localparam int STAGES = 16;

  logic [31:0]       op_q [STAGES];
  logic [31:0]       rt_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [63:0]       nxt  [STAGES];
  logic              unused_bits;

  // Restoring digit step; rt carries the partial root aligned to the current test bit.
  function automatic logic [63:0] step(input logic [31:0] op, input logic [31:0] rt, input int k);
    logic [31:0] one;
    logic [31:0] trial;
    one   = 32'h4000_0000 >> (2 * k);
    trial = rt + one;
    if (op >= trial) step = {op - trial, (rt >> 1) + one};
    else             step = {op, rt >> 1};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign nxt[k] = step(x_i, 32'd0, k);
    end else begin : g_rest
      assign nxt[k] = step(op_q[k-1], rt_q[k-1], k);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        op_q[k] <= '0;
        rt_q[k] <= '0;
      end
    end else begin
      vld_q <= {vld_q[STAGES-2:0], x_vld_i};
      for (int k = 0; k < STAGES; k++) begin
        op_q[k] <= nxt[k][63:32];
        rt_q[k] <= nxt[k][31:0];
      end
    end
  end

  assign y_vld_o     = vld_q[STAGES-1];
  assign y_o         = rt_q[STAGES-1][15:0];
  assign unused_bits = ^{op_q[STAGES-1], rt_q[STAGES-1][31:16]};

endmodule

// File: rtl/formula_1_isqrt_sequencer.sv
// res = isqrt(a) + isqrt(b) + isqrt(c) through one shared isqrt, one argument set per 3 cycles.
//   state | meaning
//   IDLE  | waiting for an argument set, isqrt input parked on c_q
//   S_A   | issuing a_q
//   S_B   | issuing b_q
//   S_C   | issuing c_q, may accept the next set back-to-back
module formula_1_isqrt_sequencer
  import formula_1_seq_pkg::*;
#(
  parameter int ISQRT_LATENCY = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  formula_1_isqrt_sequencer_if.slave  bus
);

  localparam int IF_W = $clog2(3 * ISQRT_LATENCY + 4);

  seq_state_e        state_q;
  logic [31:0]       a_q, b_q, c_q;
  logic [1:0]        phase_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  res_sum_q;
  logic              res_vld_q;
  logic [IF_W-1:0]   inflight_q;

  logic              arg_rdy;
  logic              transfer;
  logic              x_vld;
  logic [31:0]       x;
  logic              y_vld;
  logic [ROOT_W-1:0] y;
  logic [ACC_W-1:0]  y_ext;

  assign arg_rdy  = (state_q == IDLE) || (state_q == S_C);
  assign transfer = bus.arg_vld && arg_rdy;
  assign x_vld    = (state_q != IDLE);
  assign y_ext    = {{(ACC_W-ROOT_W){1'b0}}, y};

  always_comb begin
    unique case (state_q)
      S_A:     x = a_q;
      S_B:     x = b_q;
      default: x = c_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      if (transfer) begin
        a_q <= bus.a;
        b_q <= bus.b;
        c_q <= bus.c;
      end
      unique case (state_q)
        IDLE:    state_q <= transfer ? S_A : IDLE;
        S_A:     state_q <= S_B;
        S_B:     state_q <= S_C;
        default: state_q <= transfer ? S_A : IDLE;
      endcase
    end
  end

  // Results return in issue order, so the phase alone says which operand y belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_A;
      acc_q     <= '0;
      res_sum_q <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (y_vld) begin
        unique case (phase_q)
          PH_A: begin
            acc_q   <= y_ext;
            phase_q <= PH_B;
          end
          PH_B: begin
            acc_q   <= acc_q + y_ext;
            phase_q <= PH_C;
          end
          default: begin
            res_sum_q <= acc_q + y_ext;
            res_vld_q <= 1'b1;
            phase_q   <= PH_A;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      unique case ({x_vld, y_vld})
        2'b10:   inflight_q <= inflight_q + IF_W'(1);
        2'b01:   inflight_q <= inflight_q - IF_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  formula_1_isqrt_sequencer_isqrt u_isqrt (
    .clk_i   (clk),
    .rst_i   (~rst_n),
    .x_vld_i (x_vld),
    .x_i     (x),
    .y_vld_o (y_vld),
    .y_o     (y)
  );

  assign bus.arg_rdy = arg_rdy;
  assign bus.res_vld = res_vld_q;
  assign bus.res     = {{(DATA_W-ACC_W){1'b0}}, res_sum_q};
  assign bus.busy    = (state_q != IDLE) || (inflight_q != '0);

endmodule
